audio_i2s_out: RTL and testbench
================================

Name: audio_i2s_out

Overview:
Downstream stage of the synth engine. It buffers the mixed TONE samples written by the engine's LD_FIFO strobe in a small FIFO, and returns FIFO_FULL as backpressure. It scales and saturates each sample to 24-bit signed and serializes it to the audio codec DAC in I2S format. The codec is I2S master (supplies AUD_BCLK and AUD_DACLRCK, 44.1 kHz frame rate); this block is an I2S slave transmitter clocked entirely from CLK.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
OUT_SHIFT, 8, arithmetic right shift applied to TONE before saturation
SAMPLE_W, 24, bits per I2S channel word (fixed 24 in this revision)

Ports:
CLK  in  1  system clock, 50 MHz; must be >= 8x AUD_BCLK
RESET  in  1  reset, asynchronous, active-high
LD_FIFO  in  1  write strobe from synth engine, one cycle per sample
TONE  in  32  signed mixed sample, valid when LD_FIFO=1
FIFO_FULL  out  1  FIFO holds DEPTH entries; writes are dropped
FIFO_COUNT  out  $clog2(DEPTH)+1  current occupancy
AUD_BCLK  in  1  codec bit clock (asynchronous to CLK)
AUD_DACLRCK  in  1  codec frame clock; 0 = left, 1 = right
AUD_DACDAT  out  1  serial DAC data
UNDERRUN  out  1  sticky; set when a frame starts with the FIFO empty
OVERFLOW  out  1  sticky; set when LD_FIFO=1 while FIFO_FULL=1

Behaviour:
Reset values:
- FIFO_COUNT=0, FIFO_FULL=0, AUD_DACDAT=0, UNDERRUN=0, OVERFLOW=0.
- State IDLE; held sample = 0; synchronizer flops = 0.

FIFO (shared clock):
- Write when LD_FIFO && !FIFO_FULL. Write while full is dropped and sets OVERFLOW.
- FIFO_FULL is registered: FIFO_FULL = (count == DEPTH).
- Write and pop in the same cycle: accepted if not full, count unchanged. A write while full is rejected even if a pop occurs in that cycle.
- Pop on empty is suppressed and sets UNDERRUN. A simultaneous write to an empty FIFO is accepted.
- Pointers wrap modulo DEPTH.

Synchronisation:
- AUD_BCLK and AUD_DACLRCK each pass through 2 flops, plus a third flop for edge detection.
- bclk_fall = prev & !cur; lr_fall and lr_rise defined the same way.
- Edge-to-action latency is 3 CLK cycles, identical on both signals.

Conversion (registered at pop):
- s = TONE >>> OUT_SHIFT.
- If s > 2^23-1, word = 24'h7FFFFF. If s < -2^23, word = 24'h800000. Otherwise word = s[23:0].

State machine (IDLE, LEFT, RIGHT):
- IDLE: AUD_DACDAT=0; ignore everything until lr_fall, so output never starts mid-frame.
- lr_fall (any state): pop the FIFO. If non-empty, held := converted sample; if empty, held is unchanged (repeats the last sample) and UNDERRUN is set. Load the shift register with held, bit_cnt := 0, go to LEFT.
- lr_rise in LEFT: reload the shift register with the same held word (mono on both channels), bit_cnt := 0, go to RIGHT.
- lr_rise in IDLE is ignored.
- Shifting: the bclk_fall coincident with the LRCK edge shifts nothing (the I2S 1-bit delay). Each subsequent bclk_fall drives the shift register MSB to AUD_DACDAT, shifts left, and increments bit_cnt. After SAMPLE_W bits, AUD_DACDAT=0 until the next LRCK edge. bit_cnt saturates at SAMPLE_W.
- An LRCK edge arriving before SAMPLE_W bits are sent truncates the word; no error is raised.
- Each pop occurs exactly once per frame, at lr_fall only.

Reset mid-operation:
- Asynchronous clear of all state and the FIFO contents.
- AUD_DACDAT goes to 0 immediately.
- After release, the block waits in IDLE for the next lr_fall.

Decomposition:
- Package audio_pkg: SAMPLE_W, I2S state enum {IDLE, LEFT, RIGHT}, saturation limits SAT_MAX=24'h7FFFFF and SAT_MIN=24'h800000.
- Sub-module sample_fifo (DEPTH, width 32; ports wr, rd, din, dout, full, empty, count).
- Synchronizers, conversion and serializer stay in audio_i2s_out.

Test Plan:
- Reset, then write TONE=32'h0012_3456 and drive an I2S frame -> left and right words both 24'h001234, MSB one BCLK after each LRCK edge; FIFO_COUNT 1->0.
- TONE=32'h7FFF_FFFF and 32'h8000_0000 -> words 24'h7FFFFF and 24'h800000 (saturation); TONE=32'hFFFF_FF00 -> 24'hFFFFFF.
- 17 LD_FIFO strobes with DEPTH=16 -> FIFO_FULL=1 after the 16th; the 17th is dropped, OVERFLOW=1, count stays 16.
- Empty FIFO at lr_fall after sample 24'h00ABCD -> 24'h00ABCD repeated on both channels, UNDERRUN=1 and sticky.
- Release reset while AUD_DACLRCK=1 (mid-frame) -> AUD_DACDAT stays 0, no pop until the first lr_fall.
- LD_FIFO coincident with the pop cycle at count=3 -> count remains 3, data order preserved across 4 subsequent frames.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants, state type and saturation helper for the I2S output stage.
`timescale 1ns/1ps
package audio_pkg;

   localparam int SAMPLE_W = 24;
   localparam logic [SAMPLE_W-1:0] SAT_MAX = 24'h7FFFFF;
   localparam logic [SAMPLE_W-1:0] SAT_MIN = 24'h800000;

   typedef enum logic [1:0] {IDLE, LEFT, RIGHT} i2s_state_t;

   // Clamp an already-shifted sample into the signed 24-bit DAC range.
   function automatic logic [SAMPLE_W-1:0] saturate(input logic signed [31:0] s);
      if (s > 32'sh007F_FFFF)
         return SAT_MAX;
      else if (s < 32'shFF80_0000)
         return SAT_MIN;
      else
         return s[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock show-ahead FIFO; full flag is registered, pops on empty are ignored.
`timescale 1ns/1ps
module sample_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr,
   input  logic                     rd,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE      = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count_next;
   logic             wr_ok;
   logic             rd_ok;

   assign empty = (count == '0);
   assign wr_ok = wr && !full;
   assign rd_ok = rd && !empty;
   assign dout  = mem[rd_ptr];

   always_comb begin
      count_next = count;
      case ({wr_ok, rd_ok})
         2'b10:   count_next = count + ONE;
         2'b01:   count_next = count - ONE;
         default: count_next = count;
      endcase
   end

   // Pointers are exactly AW bits wide so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (wr_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (rd_ok)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count_next;
         full  <= (count_next == FULL_CNT);
      end
   end

endmodule

// File: rtl/audio_i2s_out.sv
// I2S slave transmitter: buffers engine samples, scales/saturates them and shifts them to the codec DAC.
`timescale 1ns/1ps
module audio_i2s_out
   import audio_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int OUT_SHIFT = 8
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     LD_FIFO,
   input  logic [31:0]              TONE,
   output logic                     FIFO_FULL,
   output logic [$clog2(DEPTH):0]   FIFO_COUNT,
   input  logic                     AUD_BCLK,
   input  logic                     AUD_DACLRCK,
   output logic                     AUD_DACDAT,
   output logic                     UNDERRUN,
   output logic                     OVERFLOW
);

   localparam int CNT_W = $clog2(SAMPLE_W + 1);
   localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(SAMPLE_W);

   logic [2:0]          bclk_sync;
   logic [2:0]          lr_sync;
   logic                bclk_fall;
   logic                lr_fall;
   logic                lr_rise;
   i2s_state_t          state;
   i2s_state_t          state_next;
   logic                pop;
   logic                load;
   logic                fifo_empty;
   logic [31:0]         fifo_dout;
   logic signed [31:0]  shifted;
   logic [SAMPLE_W-1:0] conv_word;
   logic [SAMPLE_W-1:0] held;
   logic [SAMPLE_W-1:0] shreg;
   logic [CNT_W-1:0]    bit_cnt;

   sample_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk   (CLK),
      .rst   (RESET),
      .wr    (LD_FIFO),
      .rd    (pop),
      .din   (TONE),
      .dout  (fifo_dout),
      .full  (FIFO_FULL),
      .empty (fifo_empty),
      .count (FIFO_COUNT)
   );

   assign shifted   = $signed(fifo_dout) >>> OUT_SHIFT;
   assign conv_word = saturate(shifted);

   // Two metastability flops plus one history flop per codec clock.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         bclk_sync <= '0;
         lr_sync   <= '0;
      end else begin
         bclk_sync <= {bclk_sync[1:0], AUD_BCLK};
         lr_sync   <= {lr_sync[1:0], AUD_DACLRCK};
      end
   end

   assign bclk_fall = bclk_sync[2] & ~bclk_sync[1];
   assign lr_fall   = lr_sync[2]   & ~lr_sync[1];
   assign lr_rise   = ~lr_sync[2]  &  lr_sync[1];

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      load       = 1'b0;
      if (lr_fall) begin
         pop        = 1'b1;
         load       = 1'b1;
         state_next = LEFT;
      end else if (lr_rise && state == LEFT) begin
         load       = 1'b1;
         state_next = RIGHT;
      end
   end

   // A load wins over a coincident BCLK fall, which gives the one-bit I2S delay.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         held       <= '0;
         shreg      <= '0;
         bit_cnt    <= '0;
         AUD_DACDAT <= 1'b0;
         UNDERRUN   <= 1'b0;
         OVERFLOW   <= 1'b0;
      end else begin
         if (LD_FIFO && FIFO_FULL)
            OVERFLOW <= 1'b1;
         if (pop) begin
            if (fifo_empty)
               UNDERRUN <= 1'b1;
            else
               held <= conv_word;
         end
         if (load) begin
            shreg   <= (pop && !fifo_empty) ? conv_word : held;
            bit_cnt <= '0;
         end else if (state == IDLE) begin
            AUD_DACDAT <= 1'b0;
         end else if (bclk_fall) begin
            if (bit_cnt < WORD_BITS) begin
               AUD_DACDAT <= shreg[SAMPLE_W-1];
               shreg      <= {shreg[SAMPLE_W-2:0], 1'b0};
               bit_cnt    <= bit_cnt + 1'b1;
            end else begin
               AUD_DACDAT <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_audio_i2s_out.sv
// Directed bench for audio_i2s_out: acts as the codec (BCLK/LRCK master) and the synth engine.
`timescale 1ns/1ps
module tb_audio_i2s_out;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        LD_FIFO;
   logic [31:0] TONE;
   logic        FIFO_FULL;
   logic [4:0]  FIFO_COUNT;
   logic        AUD_BCLK;
   logic        AUD_DACLRCK;
   logic        AUD_DACDAT;
   logic        UNDERRUN;
   logic        OVERFLOW;

   int checks   = 0;
   int failures = 0;

   audio_i2s_out #(
      .DEPTH     (16),
      .OUT_SHIFT (8)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .LD_FIFO     (LD_FIFO),
      .TONE        (TONE),
      .FIFO_FULL   (FIFO_FULL),
      .FIFO_COUNT  (FIFO_COUNT),
      .AUD_BCLK    (AUD_BCLK),
      .AUD_DACLRCK (AUD_DACLRCK),
      .AUD_DACDAT  (AUD_DACDAT),
      .UNDERRUN    (UNDERRUN),
      .OVERFLOW    (OVERFLOW)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] tone);
      @(negedge CLK);
      LD_FIFO = 1'b1;
      TONE    = tone;
      @(negedge CLK);
      LD_FIFO = 1'b0;
   endtask

   task automatic applyReset();
      @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
   endtask

   // One LRCK half: 26 BCLK periods of 160 ns; data is sampled on BCLK rising edges.
   task automatic driveHalf(input logic lr, input logic ld, input logic [31:0] tone,
                            output logic [23:0] word, output logic tail);
      logic [23:0] w;
      w = '0;
      AUD_DACLRCK = lr;
      AUD_BCLK    = 1'b0;
      #20;
      LD_FIFO = ld;
      TONE    = tone;
      #10;
      LD_FIFO = 1'b0;
      #50;
      AUD_BCLK = 1'b1;
      #80;
      for (int i = 0; i < 24; i++) begin
         AUD_BCLK = 1'b0;
         #80;
         AUD_BCLK = 1'b1;
         w = {w[22:0], AUD_DACDAT};
         #80;
      end
      AUD_BCLK = 1'b0;
      #80;
      AUD_BCLK = 1'b1;
      tail = AUD_DACDAT;
      #80;
      word = w;
   endtask

   task automatic checkFrame(input string tag, input logic ld, input logic [31:0] tone,
                             input logic [23:0] exp_word);
      logic [23:0] lw, rw;
      logic        lt, rt;
      driveHalf(1'b0, ld, tone, lw, lt);
      driveHalf(1'b1, 1'b0, 32'h0, rw, rt);
      checkOutput({tag, "_left"},  32'(lw), 32'(exp_word));
      checkOutput({tag, "_right"}, 32'(rw), 32'(exp_word));
      checkOutput({tag, "_ltail"}, 32'(lt), 32'h0);
      checkOutput({tag, "_rtail"}, 32'(rt), 32'h0);
   endtask

   initial begin
      logic [23:0] idle_word;
      logic        idle_tail;
      RESET       = 1'b0;
      LD_FIFO     = 1'b0;
      TONE        = '0;
      AUD_BCLK    = 1'b1;
      AUD_DACLRCK = 1'b1;

      // Reset state
      applyReset();
      checkOutput("rst_count",    32'(FIFO_COUNT), 32'd0);
      checkOutput("rst_full",     32'(FIFO_FULL),  32'd0);
      checkOutput("rst_dacdat",   32'(AUD_DACDAT), 32'd0);
      checkOutput("rst_underrun", 32'(UNDERRUN),   32'd0);
      checkOutput("rst_overflow", 32'(OVERFLOW),   32'd0);

      // Basic mono frame
      applyStimulus(32'h0012_3456);
      checkOutput("basic_count1", 32'(FIFO_COUNT), 32'd1);
      checkFrame("basic", 1'b0, 32'h0, 24'h001234);
      checkOutput("basic_count0", 32'(FIFO_COUNT), 32'd0);
      checkOutput("basic_underrun", 32'(UNDERRUN), 32'd0);

      // Saturation and sign handling
      applyStimulus(32'h7FFF_FFFF);
      applyStimulus(32'h8000_0000);
      applyStimulus(32'hFFFF_FF00);
      checkOutput("sat_count3", 32'(FIFO_COUNT), 32'd3);
      checkFrame("sat_max", 1'b0, 32'h0, 24'h7FFFFF);
      checkFrame("sat_min", 1'b0, 32'h0, 24'h800000);
      checkFrame("neg_one", 1'b0, 32'h0, 24'hFFFFFF);
      checkOutput("sat_underrun", 32'(UNDERRUN), 32'd0);

      // Underrun repeats the held sample and is sticky
      applyStimulus(32'h00AB_CD00);
      checkFrame("ur_first", 1'b0, 32'h0, 24'h00ABCD);
      checkOutput("ur_before", 32'(UNDERRUN), 32'd0);
      checkFrame("ur_repeat", 1'b0, 32'h0, 24'h00ABCD);
      checkOutput("ur_set", 32'(UNDERRUN), 32'd1);
      checkFrame("ur_repeat2", 1'b0, 32'h0, 24'h00ABCD);
      checkOutput("ur_sticky", 32'(UNDERRUN), 32'd1);

      // Fill to DEPTH, then overflow
      applyReset();
      checkOutput("ovf_rst_underrun", 32'(UNDERRUN), 32'd0);
      for (int i = 1; i <= 15; i++)
         applyStimulus(32'(i) << 8);
      checkOutput("ovf_count15", 32'(FIFO_COUNT), 32'd15);
      checkOutput("ovf_full15",  32'(FIFO_FULL),  32'd0);
      applyStimulus(32'h0000_1000);
      checkOutput("ovf_count16", 32'(FIFO_COUNT), 32'd16);
      checkOutput("ovf_full16",  32'(FIFO_FULL),  32'd1);
      checkOutput("ovf_clear16", 32'(OVERFLOW),   32'd0);
      applyStimulus(32'h0000_1100);
      checkOutput("ovf_count17", 32'(FIFO_COUNT), 32'd16);
      checkOutput("ovf_full17",  32'(FIFO_FULL),  32'd1);
      checkOutput("ovf_set",     32'(OVERFLOW),   32'd1);
      checkFrame("ovf_drain", 1'b0, 32'h0, 24'h000001);
      checkOutput("ovf_count_after", 32'(FIFO_COUNT), 32'd15);
      checkOutput("ovf_full_after",  32'(FIFO_FULL),  32'd0);

      // Reset released with LRCK high: stay silent until the first LRCK fall
      applyReset();
      checkOutput("mid_dacdat",   32'(AUD_DACDAT), 32'd0);
      checkOutput("mid_overflow", 32'(OVERFLOW),   32'd0);
      checkOutput("mid_count0",   32'(FIFO_COUNT), 32'd0);
      applyStimulus(32'h0055_5500);
      driveHalf(1'b1, 1'b0, 32'h0, idle_word, idle_tail);
      checkOutput("mid_idle_word",  32'(idle_word),  32'h0);
      checkOutput("mid_idle_tail",  32'(idle_tail),  32'h0);
      checkOutput("mid_idle_count", 32'(FIFO_COUNT), 32'd1);
      checkFrame("mid_first", 1'b0, 32'h0, 24'h005555);
      checkOutput("mid_count_after", 32'(FIFO_COUNT), 32'd0);

      // Write coincident with the pop cycle keeps the count and the order
      applyStimulus(32'h0011_1100);
      applyStimulus(32'h0022_2200);
      applyStimulus(32'h0033_3300);
      checkOutput("ord_count3", 32'(FIFO_COUNT), 32'd3);
      checkFrame("ord_1", 1'b1, 32'h0044_4400, 24'h001111);
      checkOutput("ord_count_kept", 32'(FIFO_COUNT), 32'd3);
      checkFrame("ord_2", 1'b0, 32'h0, 24'h002222);
      checkFrame("ord_3", 1'b0, 32'h0, 24'h003333);
      checkFrame("ord_4", 1'b0, 32'h0, 24'h004444);
      checkOutput("ord_count0",   32'(FIFO_COUNT), 32'd0);
      checkOutput("ord_underrun", 32'(UNDERRUN),   32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
